// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter register with reset/interrupt vector sequencing.
// The interrupt path (INT_* states, pend, ie, ret_pc, intr_ack) is built only when PC_INTR_EN is defined.
module pc_ctrl #(
    parameter int              WIDTH          = 8,
    parameter logic [WIDTH-1:0] RESET_VEC_ADDR = '0,
    parameter logic [WIDTH-1:0] INT_VEC_ADDR   = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pc_next,
    input  logic             pc_we,
    input  logic             stall,
    input  logic             intr,
    input  logic             rti,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             vec_rd,
    output logic [WIDTH-1:0] vec_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus1,
    output logic [WIDTH-1:0] ret_pc,
    output logic             intr_ack,
    output logic             busy
);
    typedef enum logic [2:0] {
        BOOT,
        BOOT_WAIT,
        RUN
`ifdef PC_INTR_EN
        , INT_FETCH,
        INT_WAIT
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             retire, take;

    assign retire   = (state_q == RUN) && !stall && pc_we;
    assign pc       = pc_q;
    assign pc_plus1 = pc_q + WIDTH'(1);
    assign busy     = state_q != RUN;

`ifdef PC_INTR_EN
    logic             intr_q, pend_q, pend_d, ie_q, ie_d, ack_q;
    logic [WIDTH-1:0] ret_pc_q, ret_pc_d;

    // Registered ie means an rti retire can never also take an interrupt.
    assign take     = retire && pend_q && ie_q;
    assign ret_pc   = ret_pc_q;
    assign intr_ack = ack_q;

    always_comb begin
        pend_d   = take ? 1'b0 : pend_q | (intr & ~intr_q);
        ie_d     = take ? 1'b0 : (retire && rti) ? 1'b1 : ie_q;
        ret_pc_d = take ? pc_next : ret_pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intr_q   <= 1'b0;
            pend_q   <= 1'b0;
            ie_q     <= 1'b1;
            ack_q    <= 1'b0;
            ret_pc_q <= '0;
        end else begin
            intr_q   <= intr;
            pend_q   <= pend_d;
            ie_q     <= ie_d;
            ack_q    <= take;
            ret_pc_q <= ret_pc_d;
        end
    end
`else
    logic unused_intr;

    assign unused_intr = intr ^ rti;
    assign take        = 1'b0;
    assign ret_pc      = '0;
    assign intr_ack    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        vec_rd   = 1'b0;
        vec_addr = '0;
        case (state_q)
            BOOT: begin
                vec_rd   = 1'b1;
                vec_addr = RESET_VEC_ADDR;
                state_d  = BOOT_WAIT;
            end
            BOOT_WAIT: begin
                pc_d    = mem_rdata;
                state_d = RUN;
            end
            RUN: begin
                pc_d = (retire && !take) ? pc_next : pc_q;
`ifdef PC_INTR_EN
                state_d = take ? INT_FETCH : RUN;
`endif
            end
`ifdef PC_INTR_EN
            INT_FETCH: begin
                vec_rd   = 1'b1;
                vec_addr = INT_VEC_ADDR;
                state_d  = INT_WAIT;
            end
            INT_WAIT: begin
                pc_d    = mem_rdata;
                state_d = RUN;
            end
`endif
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end
endmodule
